sys_ctrl: RTL and testbench

SYS_CTRL -- requirements
Module: sys_ctrl

---
 rtl/sys_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_sys_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// Byte-command register-file controller: 0xAA addr data writes, 0xBB addr reads and returns the byte.
// Optional inter-byte timeout enabled by defining SYS_CTRL_TIMEOUT_EN.
module sys_ctrl #(
    parameter int ADDRESS_BITS   = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [DATA_WIDTH-1:0]   i_RX_data,
    input  logic                    i_RX_valid,
    output logic [ADDRESS_BITS-1:0] o_Address,
    output logic                    o_WrEn,
    output logic                    o_RdEn,
    output logic [DATA_WIDTH-1:0]   o_WrData,
    input  logic [DATA_WIDTH-1:0]   i_RdData,
    input  logic                    i_RdData_valid,
    output logic [DATA_WIDTH-1:0]   o_TX_data,
    output logic                    o_TX_valid,
    input  logic                    i_TX_busy,
    output logic                    o_busy,
    output logic                    o_frame_err,
    output logic [2:0]              o_dbg_state
);

    // Handshakes: i_RX_valid, i_RdData_valid and o_TX_valid are one-cycle
    // strobes with no back-pressure; i_TX_busy high stalls the response in
    // TX_SEND, and a byte is handed over in the first cycle it is low.

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_SEND = 3'd5
    } state_t;

    localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'hBB);

    state_t                    state_q, state_d;
    logic [ADDRESS_BITS-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
    logic                      wr_en_q, wr_en_d;
    logic                      rd_en_q, rd_en_d;
    logic                      tx_valid_q, tx_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      addr_ok;
    logic                      tmo_hit;

    // Address bytes with any bit above the address field are out of range.
    assign addr_ok = ((i_RX_data >> ADDRESS_BITS) == '0);

`ifdef SYS_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_run;

    assign tmo_run = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR);
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a byte.
    assign tmo_hit = tmo_run && !i_RX_valid && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (!tmo_run || i_RX_valid || tmo_hit) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        tx_data_d   = tx_data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        tx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_RX_valid) begin
                    if (i_RX_data == CMD_WR) begin
                        state_d = WR_ADDR;
                    end else if (i_RX_data == CMD_RD) begin
                        state_d = RD_ADDR;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            WR_ADDR: begin
                if (i_RX_valid) begin
                    if (addr_ok) begin
                        addr_d  = i_RX_data[ADDRESS_BITS-1:0];
                        state_d = WR_DATA;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (tmo_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            WR_DATA: begin
                if (i_RX_valid) begin
                    wr_data_d = i_RX_data;
                    wr_en_d   = 1'b1;
                    state_d   = IDLE;
                end else if (tmo_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            RD_ADDR: begin
                if (i_RX_valid) begin
                    if (addr_ok) begin
                        addr_d  = i_RX_data[ADDRESS_BITS-1:0];
                        rd_en_d = 1'b1;
                        state_d = RD_WAIT;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (tmo_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            RD_WAIT: begin
                // A stray byte is dropped but the read keeps going.
                frame_err_d = i_RX_valid;
                if (i_RdData_valid) begin
                    tx_data_d = i_RdData;
                    state_d   = TX_SEND;
                end
            end

            TX_SEND: begin
                frame_err_d = i_RX_valid;
                if (!i_TX_busy) begin
                    tx_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wr_data_q   <= '0;
            tx_data_q   <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            tx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            tx_data_q   <= tx_data_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            tx_valid_q  <= tx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_Address   = addr_q;
    assign o_WrEn      = wr_en_q;
    assign o_RdEn      = rd_en_q;
    assign o_WrData    = wr_data_q;
    assign o_TX_data   = tx_data_q;
    assign o_TX_valid  = tx_valid_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = (state_q != IDLE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed self-checking bench for sys_ctrl: write, read with TX stall, framing errors, reset, timeout.
module tb_sys_ctrl;

  localparam int AB = 4;
  localparam int DW = 8;
  localparam int TO = 255;

  localparam logic [31:0] S_IDLE    = 32'd0;
  localparam logic [31:0] S_WR_ADDR = 32'd1;
  localparam logic [31:0] S_WR_DATA = 32'd2;
  localparam logic [31:0] S_RD_WAIT = 32'd4;
  localparam logic [31:0] S_TX_SEND = 32'd5;

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic [DW-1:0] i_RX_data = '0;
  logic          i_RX_valid = 1'b0;
  logic [AB-1:0] o_Address;
  logic          o_WrEn;
  logic          o_RdEn;
  logic [DW-1:0] o_WrData;
  logic [DW-1:0] i_RdData = '0;
  logic          i_RdData_valid = 1'b0;
  logic [DW-1:0] o_TX_data;
  logic          o_TX_valid;
  logic          i_TX_busy = 1'b0;
  logic          o_busy;
  logic          o_frame_err;
  logic [2:0]    o_dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int tx_cnt = 0;
  int both_cnt = 0;

  sys_ctrl #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_RX_data(i_RX_data),
    .i_RX_valid(i_RX_valid),
    .o_Address(o_Address),
    .o_WrEn(o_WrEn),
    .o_RdEn(o_RdEn),
    .o_WrData(o_WrData),
    .i_RdData(i_RdData),
    .i_RdData_valid(i_RdData_valid),
    .o_TX_data(o_TX_data),
    .o_TX_valid(o_TX_valid),
    .i_TX_busy(i_TX_busy),
    .o_busy(o_busy),
    .o_frame_err(o_frame_err),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  // strobe monitor, sampled mid-cycle
  always @(negedge i_clk) begin
    if (o_WrEn) wr_cnt++;
    if (o_RdEn) rd_cnt++;
    if (o_TX_valid) tx_cnt++;
    if (o_WrEn && o_RdEn) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: all drive happens 2 time units after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #2;
  endtask

  task automatic send(input logic [DW-1:0] b);
    i_RX_data  = b;
    i_RX_valid = 1'b1;
    tick(1);
    i_RX_valid = 1'b0;
  endtask

  task automatic return_rdata(input logic [DW-1:0] d);
    i_RdData       = d;
    i_RdData_valid = 1'b1;
    tick(1);
    i_RdData_valid = 1'b0;
  endtask

  initial begin
    int wr0, rd0, tx0, stall_tx;

    // reset state, held across clock edges
    repeat (3) @(posedge i_clk);
    #2;
    check("rst_state", 32'(o_dbg_state), S_IDLE);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_addr", 32'(o_Address), 32'd0);
    check("rst_wrdata", 32'(o_WrData), 32'd0);
    check("rst_txdata", 32'(o_TX_data), 32'd0);
    check("rst_strobes", {28'd0, o_WrEn, o_RdEn, o_TX_valid, o_frame_err}, 32'd0);
    i_reset = 1'b1;
    tick(1);

    // write 0xAA 0x05 0x3C
    wr0 = wr_cnt; rd0 = rd_cnt;
    send(8'hAA);
    check("wr_state_addr", 32'(o_dbg_state), S_WR_ADDR);
    check("wr_busy", 32'(o_busy), 32'd1);
    send(8'h05);
    check("wr_state_data", 32'(o_dbg_state), S_WR_DATA);
    check("wr_addr_latch", 32'(o_Address), 32'd5);
    check("wr_en_early", 32'(o_WrEn), 32'd0);
    send(8'h3C);
    check("wr_en", 32'(o_WrEn), 32'd1);
    check("wr_data", 32'(o_WrData), 32'h3C);
    check("wr_addr", 32'(o_Address), 32'd5);
    check("wr_idle", 32'(o_dbg_state), S_IDLE);
    check("wr_busy_off", 32'(o_busy), 32'd0);

    // back-to-back read 0xBB 0x02 with TX stall of 10 cycles
    i_TX_busy = 1'b1;
    send(8'hBB);
    check("wr_en_drop", 32'(o_WrEn), 32'd0);
    send(8'h02);
    check("rd_en", 32'(o_RdEn), 32'd1);
    check("rd_addr", 32'(o_Address), 32'd2);
    check("rd_state_wait", 32'(o_dbg_state), S_RD_WAIT);
    return_rdata(8'h81);
    check("rd_en_drop", 32'(o_RdEn), 32'd0);
    check("rd_state_tx", 32'(o_dbg_state), S_TX_SEND);
    check("rd_txdata", 32'(o_TX_data), 32'h81);
    stall_tx = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_TX_valid) stall_tx++;
      tick(1);
    end
    check("rd_stall_txvalid", 32'(stall_tx), 32'd0);
    check("rd_stall_state", 32'(o_dbg_state), S_TX_SEND);
    i_TX_busy = 1'b0;
    tick(1);
    check("rd_txvalid", 32'(o_TX_valid), 32'd1);
    check("rd_txdata_out", 32'(o_TX_data), 32'h81);
    check("rd_idle", 32'(o_dbg_state), S_IDLE);
    tick(1);
    check("rd_txvalid_drop", 32'(o_TX_valid), 32'd0);
    check("wr_rd_counts", 32'((wr_cnt - wr0) * 16 + (rd_cnt - rd0)), 32'h11);

    // framing errors: bad command, out-of-range address
    wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_cnt;
    send(8'h55);
    check("err_cmd", 32'(o_frame_err), 32'd1);
    check("err_cmd_state", 32'(o_dbg_state), S_IDLE);
    tick(1);
    check("err_cmd_drop", 32'(o_frame_err), 32'd0);
    send(8'hAA);
    check("err_addr_pre", 32'(o_frame_err), 32'd0);
    send(8'h10);
    check("err_addr", 32'(o_frame_err), 32'd1);
    check("err_addr_state", 32'(o_dbg_state), S_IDLE);
    check("err_addr_hold", 32'(o_Address), 32'd2);
    check("err_txdata_hold", 32'(o_TX_data), 32'h81);
    tick(2);
    check("err_no_strobes", 32'((wr_cnt - wr0) + (rd_cnt - rd0) + (tx_cnt - tx0)), 32'd0);

    // stray byte during RD_WAIT
    send(8'hBB);
    send(8'h07);
    check("rw_state", 32'(o_dbg_state), S_RD_WAIT);
    send(8'h99);
    check("rw_err", 32'(o_frame_err), 32'd1);
    check("rw_state_kept", 32'(o_dbg_state), S_RD_WAIT);
    return_rdata(8'h5A);
    check("rw_state_tx", 32'(o_dbg_state), S_TX_SEND);
    tick(1);
    check("rw_txvalid", 32'(o_TX_valid), 32'd1);
    check("rw_txdata", 32'(o_TX_data), 32'h5A);
    check("rw_addr", 32'(o_Address), 32'd7);
    tick(1);

    // reset mid-frame
    wr0 = wr_cnt; rd0 = rd_cnt;
    send(8'hAA);
    send(8'h03);
    check("mr_state_pre", 32'(o_dbg_state), S_WR_DATA);
    #1;
    i_reset = 1'b0;
    #1;
    check("mr_async_state", 32'(o_dbg_state), S_IDLE);
    check("mr_async_addr", 32'(o_Address), 32'd0);
    check("mr_async_busy", 32'(o_busy), 32'd0);
    tick(2);
    i_reset = 1'b1;
    tick(1);
    check("mr_no_write", 32'(wr_cnt - wr0), 32'd0);
    send(8'hBB);
    check("mr_cmd_state", 32'(o_dbg_state), 32'd3);
    send(8'h03);
    check("mr_rd_en", 32'(o_RdEn), 32'd1);
    check("mr_rd_addr", 32'(o_Address), 32'd3);
    return_rdata(8'h44);
    tick(1);
    check("mr_txvalid", 32'(o_TX_valid), 32'd1);
    check("mr_txdata", 32'(o_TX_data), 32'h44);
    tick(1);
    check("mr_counts", 32'((wr_cnt - wr0) * 16 + (rd_cnt - rd0)), 32'h01);

    // inter-byte timeout
    send(8'hAA);
`ifdef SYS_CTRL_TIMEOUT_EN
    tick(TO - 1);
    check("to_before_state", 32'(o_dbg_state), S_WR_ADDR);
    check("to_before_err", 32'(o_frame_err), 32'd0);
    tick(1);
    check("to_err", 32'(o_frame_err), 32'd1);
    check("to_state", 32'(o_dbg_state), S_IDLE);
`else
    tick(1000);
    check("nto_state", 32'(o_dbg_state), S_WR_ADDR);
    check("nto_busy", 32'(o_busy), 32'd1);
    check("nto_err", 32'(o_frame_err), 32'd0);
    send(8'h09);
    send(8'hE7);
    check("nto_wr_en", 32'(o_WrEn), 32'd1);
    check("nto_wr_data", 32'(o_WrData), 32'hE7);
    check("nto_wr_addr", 32'(o_Address), 32'd9);
`endif
    tick(2);
    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
